spi_sel_scheduler: RTL and testbench

Round-robin scheduler that shares one SPI shift engine and the 4-bit slave-select mux (`sel`) among up to 16 requesters. It picks a requester, drives `sel` for the duration of a transaction, runs a fixed-length mode-0 SPI transfer with the data from the multiplexed slave on `spi_miso`, and returns the received word to the requester. It sits between per-slave client logic and the `sel`-driven SDO mux.

---
 rtl/spi_sel_scheduler_pkg.sv | 40 ++++
 rtl/spi_sel_scheduler_if.sv | 20 ++
 rtl/spi_sel_scheduler_engine.sv | 80 ++++++++
 rtl/spi_sel_scheduler.sv | 100 ++++++++++
 tb/tb_spi_sel_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sel_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sched_pkg: shared types and the round-robin pick helper          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_sched_pkg;

  localparam int SEL_W   = 4;
  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Descending scan so the candidate closest after `last` is written last and wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   last);
    rr_pick_t         res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      cand = last + SEL_W'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sel_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sched_if: requester-side request/grant/result bus                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface spi_sched_if #(
  parameter int NREQ = 16,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] tx_data;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               done;
  logic [DW-1:0]      rx_data;

  modport master (output req, tx_data, input grant, busy, done, rx_data);
  modport slave  (input req, tx_data, output grant, busy, done, rx_data);
endinterface
`default_nettype wire

// File: rtl/spi_sel_scheduler_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_shift_engine: fixed-length SPI mode-0 shifter with SCK divider   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_shift_engine #(
  parameter int DW     = 8,
  parameter int CLKDIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] tx_word,
  input  logic          spi_miso,
  output logic          spi_sck,
  output logic          spi_mosi,
  output logic [DW-1:0] rx_word,
  output logic          fin
);
  localparam int BIT_W = $clog2(DW + 1);
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW);

  logic             r_active;
  logic             r_sck;
  logic             r_fin;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bits;
  logic [DW-1:0]    r_sr;
  logic [DW-1:0]    r_rx;

  // The start cycle counts as the first cycle of the leading low half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_fin    <= 1'b0;
      r_div    <= '0;
      r_bits   <= '0;
      r_sr     <= '0;
      r_rx     <= '0;
    end else begin
      r_fin <= 1'b0;
      if (start) begin
        r_active <= 1'b1;
        r_sck    <= 1'b0;
        r_div    <= '0;
        r_bits   <= '0;
        r_sr     <= tx_word;
        r_rx     <= '0;
      end else if (r_active) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          if (!r_sck) begin
            r_sck  <= 1'b1;
            r_rx   <= (r_rx << 1) | DW'(spi_miso);
            r_bits <= r_bits + BIT_W'(1);
          end else begin
            r_sck <= 1'b0;
            r_sr  <= r_sr << 1;
            if (r_bits == BIT_LAST) begin
              r_active <= 1'b0;
              r_fin    <= 1'b1;
            end
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  assign spi_sck  = r_sck;
  assign spi_mosi = r_sr[DW-1];
  assign rx_word  = r_rx;
  assign fin      = r_fin;

endmodule
`default_nettype wire

// File: rtl/spi_sel_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sel_scheduler: round-robin owner of one SPI engine and sel mux   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_sel_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ   = 16,
  parameter int DW     = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_sched_if.slave       bus,
  output logic [SEL_W-1:0] sel,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  sched_state_t     r_state;
  logic [NREQ-1:0]  r_grant;
  logic             r_busy;
  logic             r_done;
  logic [DW-1:0]    r_rx;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;

  rr_pick_t         w_pick;
  logic             w_launch;
  logic             w_fin;
  logic [DW-1:0]    w_tx_word;
  logic [DW-1:0]    w_rx_word;

  // Arbitration resolves in the cycle before ARB so grant/sel/MOSI are all valid in ARB.
  assign w_pick    = rr_pick(MAX_REQ'(bus.req), r_last);
  assign w_launch  = ((r_state == IDLE) || (r_state == DONE)) && w_pick.found;
  assign w_tx_word = bus.tx_data[int'(w_pick.idx)*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rx    <= '0;
      r_sel   <= '0;
      r_last  <= SEL_W'(NREQ - 1);
    end else begin
      r_grant <= '0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_pick.found) begin
            r_state <= ARB;
            r_grant <= NREQ'(1) << w_pick.idx;
            r_sel   <= w_pick.idx;
            r_last  <= w_pick.idx;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ARB: r_state <= SHIFT;
        SHIFT: begin
          if (w_fin) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_rx    <= w_rx_word;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  spi_shift_engine #(
    .DW     (DW),
    .CLKDIV (CLKDIV)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (w_launch),
    .tx_word  (w_tx_word),
    .spi_miso (spi_miso),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .rx_word  (w_rx_word),
    .fin      (w_fin)
  );

  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx;
  assign sel         = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_spi_sel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_sel_scheduler: directed checks for the SPI sel scheduler      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_sel_scheduler;
  import spi_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  spi_sched_if #(.NREQ(16), .DW(8)) bus ();
  logic [3:0] sel;
  logic       sck, mosi, miso;

  spi_sel_scheduler #(.NREQ(16), .DW(8), .CLKDIV(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sel(sel),
    .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso)
  );

  spi_sched_if #(.NREQ(2), .DW(1)) bus2 ();
  logic [3:0] sel2;
  logic       sck2, mosi2, miso2;

  spi_sel_scheduler #(.NREQ(2), .DW(1), .CLKDIV(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .sel(sel2),
    .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso2)
  );

  // Mode-0 slave behind the sel mux: load on grant, shift on each SCK fall.
  logic [7:0] slave_word [16];
  logic [7:0] slv_sr   = 8'h00;
  logic       slv_psck = 1'b0;
  always @(negedge clk) begin
    if (|bus.grant)            slv_sr <= slave_word[sel];
    else if (slv_psck && !sck) slv_sr <= slv_sr << 1;
    slv_psck <= sck;
  end
  assign miso = slv_sr[7];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.grant == '0 && lat < 200);
  endtask

  task automatic wait_done(output int cyc, output logic [7:0] mbits);
    logic ps;
    ps    = sck;
    cyc   = 0;
    mbits = '0;
    do begin
      tick();
      cyc++;
      if (sck && !ps) mbits = {mbits[6:0], mosi};
      ps = sck;
    end while (!bus.done && cyc < 300);
  endtask

  // mode: 0 keep req, 1 drop own bit at grant, 2 drop all bits at grant
  task automatic xfer(input int idx, input int mode, input string tag);
    int         lat, cyc;
    logic [7:0] mb, txw;
    txw = bus.tx_data[idx*8 +: 8];
    wait_grant(lat);
    chk({tag, " grant latency"}, 32'(lat), 32'd1);
    chk({tag, " grant"}, 32'(bus.grant), 32'(16'd1 << idx));
    chk({tag, " sel"}, 32'(sel), 32'(idx));
    chk({tag, " sck low in arb"}, 32'(sck), 32'd0);
    chk({tag, " mosi msb in arb"}, 32'(mosi), 32'(txw[7]));
    if (mode == 1) bus.req[idx] = 1'b0;
    else if (mode == 2) bus.req = '0;
    wait_done(cyc, mb);
    chk({tag, " done latency"}, 32'(cyc), 32'd65);
    chk({tag, " mosi bits"}, 32'(mb), 32'(txw));
    chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(slave_word[idx]));
    chk({tag, " busy at done"}, 32'(bus.busy), 32'd1);
    chk({tag, " sck low at done"}, 32'(sck), 32'd0);
    chk({tag, " sel held"}, 32'(sel), 32'(idx));
  endtask

  initial begin
    int   rises, seen;
    logic ps;
    rst          = 1'b1;
    bus.req      = '0;
    bus.tx_data  = '0;
    bus2.req     = '0;
    bus2.tx_data = '0;
    miso2        = 1'b0;
    for (int i = 0; i < 16; i++) slave_word[i] = 8'h00;

    tick();
    tick();
    chk("rst grant", 32'(bus.grant), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst sel", 32'(sel), 32'd0);
    chk("rst sck", 32'(sck), 32'd0);
    chk("rst mosi", 32'(mosi), 32'd0);
    chk("rst2 busy", 32'(bus2.busy), 32'd0);
    rst = 1'b0;

    // Single request after reset
    bus.tx_data[7:0] = 8'hA5;
    slave_word[0]    = 8'h3C;
    bus.req          = 16'h0001;
    xfer(0, 1, "t1");
    tick();
    chk("t1 idle busy", 32'(bus.busy), 32'd0);
    chk("t1 idle done", 32'(bus.done), 32'd0);
    chk("t1 rx held", 32'(bus.rx_data), 32'h3C);

    // Round robin from reset priority
    do_reset();
    bus.tx_data[2*8 +: 8]  = 8'h5A;
    bus.tx_data[15*8 +: 8] = 8'h81;
    slave_word[2]          = 8'hC3;
    slave_word[15]         = 8'h7E;
    bus.req                = 16'h8005;
    xfer(0, 1, "rr0");
    xfer(2, 1, "rr2");
    xfer(15, 1, "rr15");
    tick();
    chk("rr idle busy", 32'(bus.busy), 32'd0);

    // Wrap: last is 15, so 0 precedes 15
    bus.req = 16'h8001;
    xfer(0, 1, "wrap0");
    xfer(15, 1, "wrap15");

    // Persistent requests alternate
    bus.tx_data[1*8 +: 8] = 8'h96;
    slave_word[1]         = 8'h42;
    bus.req               = 16'h0003;
    xfer(0, 0, "alt0a");
    xfer(1, 0, "alt1a");
    xfer(0, 0, "alt0b");
    xfer(1, 2, "alt1b");
    tick();
    chk("alt idle busy", 32'(bus.busy), 32'd0);

    // Reset during bit 3 of a transfer to sel 7
    bus.tx_data[7*8 +: 8] = 8'hF0;
    slave_word[7]         = 8'h99;
    bus.req               = 16'h0080;
    wait_grant(rises);
    chk("mr grant latency", 32'(rises), 32'd1);
    chk("mr sel", 32'(sel), 32'd7);
    bus.req = '0;
    rises   = 0;
    ps      = sck;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      tick();
      if (sck && !ps) rises++;
      ps = sck;
    end
    chk("mr reached bit3", 32'(rises), 32'd4);
    rst = 1'b1;
    tick();
    chk("mr sck", 32'(sck), 32'd0);
    chk("mr busy", 32'(bus.busy), 32'd0);
    chk("mr sel", 32'(sel), 32'd0);
    chk("mr done", 32'(bus.done), 32'd0);
    chk("mr rx cleared", 32'(bus.rx_data), 32'd0);
    chk("mr mosi", 32'(mosi), 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    chk("mr stays quiet", 32'(seen), 32'd0);
    bus.tx_data[3*8 +: 8] = 8'h3D;
    slave_word[3]         = 8'hB6;
    bus.req               = 16'h0008;
    xfer(3, 1, "mr fresh");

    // SDO mux: only slave 0 returns ones
    for (int i = 0; i < 16; i++) begin
      slave_word[i]          = (i == 0) ? 8'hFF : 8'h00;
      bus.tx_data[i*8 +: 8]  = 8'(i * 17 + 1);
    end
    for (int i = 0; i < 16; i++) begin
      bus.req = 16'd1 << i;
      xfer(i, 1, $sformatf("mux%0d", i));
    end

    // DW=1, CLKDIV=1 instance
    miso2        = 1'b1;
    bus2.tx_data = 2'b01;
    bus2.req     = 2'b01;
    tick();
    chk("d1 grant", 32'(bus2.grant), 32'd1);
    chk("d1 sel", 32'(sel2), 32'd0);
    chk("d1 mosi", 32'(mosi2), 32'd1);
    chk("d1 sck arb", 32'(sck2), 32'd0);
    bus2.req = '0;
    tick();
    chk("d1 sck high", 32'(sck2), 32'd1);
    tick();
    chk("d1 sck trail", 32'(sck2), 32'd0);
    chk("d1 no early done", 32'(bus2.done), 32'd0);
    tick();
    chk("d1 done +3", 32'(bus2.done), 32'd1);
    chk("d1 rx", 32'(bus2.rx_data), 32'd1);
    miso2    = 1'b0;
    bus2.req = 2'b10;
    tick();
    chk("d1b grant", 32'(bus2.grant), 32'd2);
    chk("d1b sel", 32'(sel2), 32'd1);
    chk("d1b mosi", 32'(mosi2), 32'd0);
    bus2.req = '0;
    tick();
    tick();
    tick();
    chk("d1b done +3", 32'(bus2.done), 32'd1);
    chk("d1b rx", 32'(bus2.rx_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
